// File: rtl/history_reader_if.sv
// Pixel-strobe, history-RAM read port and presented-pixel bus of the
// history reader. The reader sits on the slave side; the pixel source,
// history RAM and color detector together form the master side.
interface history_reader_if #(
    parameter int ADDR_W = 19
);
    // Pixel source
    logic              VGA_VS;
    logic              pixel_valid;
    logic [7:0]        Cb_in;
    logic [7:0]        Cr_in;

    // History RAM read port
    logic [3:0]        ram_rdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic              ram_re;

    // Presented pixel towards the color detector
    logic [ADDR_W-1:0] read_addr;
    logic [9:0]        read_x;
    logic [9:0]        read_y;
    logic [3:0]        color_history;
    logic [7:0]        Cb;
    logic [7:0]        Cr;
    logic              color_valid;

    // Frame status
    logic              frame_done;
    logic              frame_short;
    logic              overrun;

    modport slave (
        input  VGA_VS, pixel_valid, Cb_in, Cr_in, ram_rdata,
        output ram_raddr, ram_re,
        output read_addr, read_x, read_y, color_history, Cb, Cr, color_valid,
        output frame_done, frame_short, overrun
    );

    modport master (
        output VGA_VS, pixel_valid, Cb_in, Cr_in, ram_rdata,
        input  ram_raddr, ram_re,
        input  read_addr, read_x, read_y, color_history, Cb, Cr, color_valid,
        input  frame_done, frame_short, overrun
    );
endinterface

// File: rtl/history_reader.sv
// Raster-order reader of the per-pixel color-history RAM. Each accepted
// pixel strobe issues one RAM read; two cycles later the history word is
// presented together with the pixel's address, x/y and Cb/Cr. A falling
// edge on VGA_VS (re)starts the scan at pixel 0.
module history_reader #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic            clk,
    input  logic            reset,
    history_reader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [9:0]        X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Scan control
    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vs_prev_q;
    logic              overrun_q, overrun_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_short_q, frame_short_d;

    // Stage 1: pixel whose RAM read is in flight
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [9:0]        s1_x_q;
    logic [9:0]        s1_y_q;
    logic [7:0]        s1_cb_q;
    logic [7:0]        s1_cr_q;

    // Output stage: presented pixel
    logic              out_valid_q;
    logic [3:0]        out_hist_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [9:0]        out_x_q;
    logic [9:0]        out_y_q;
    logic [7:0]        out_cb_q;
    logic [7:0]        out_cr_q;

    logic vs_fall;
    logic issue;

    // Frame-start detect and read issue; reset gating keeps ram_re low while reset is held.
    assign vs_fall = vs_prev_q & ~bus.VGA_VS;
    assign issue   = reset & (state_q == S_SCAN) & bus.pixel_valid & ~vs_fall;

    assign bus.ram_re    = issue;
    assign bus.ram_raddr = issue ? addr_q : '0;

    // Next-state, raster counters and frame status.
    // NOTE: every variable gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        overrun_d     = overrun_q;
        frame_done_d  = 1'b0;
        frame_short_d = 1'b0;

        if (vs_fall) begin
            frame_short_d = (state_q == S_SCAN) && (addr_q != '0);
            state_d       = S_SCAN;
            x_d           = '0;
            y_d           = '0;
            addr_d        = '0;
            overrun_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_SCAN: begin
                    if (bus.pixel_valid) begin
                        if (x_q == X_LAST && y_q == Y_LAST) begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                            if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + 10'd1;
                            end else begin
                                x_d = x_q + 10'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.pixel_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan control registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            vs_prev_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_short_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            vs_prev_q     <= bus.VGA_VS;
            overrun_q     <= overrun_d;
            frame_done_q  <= frame_done_d;
            frame_short_q <= frame_short_d;
        end
    end

    // Two-stage read pipeline; a frame start discards whatever is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_cb_q     <= '0;
            s1_cr_q     <= '0;
            out_valid_q <= 1'b0;
            out_hist_q  <= '0;
            out_addr_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_cb_q    <= '0;
            out_cr_q    <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_addr_q <= addr_q;
                s1_x_q    <= x_q;
                s1_y_q    <= y_q;
                s1_cb_q   <= bus.Cb_in;
                s1_cr_q   <= bus.Cr_in;
            end

            if (s1_valid_q && !vs_fall) begin
                out_valid_q <= 1'b1;
                out_hist_q  <= bus.ram_rdata;
                out_addr_q  <= s1_addr_q;
                out_x_q     <= s1_x_q;
                out_y_q     <= s1_y_q;
                out_cb_q    <= s1_cb_q;
                out_cr_q    <= s1_cr_q;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.color_valid   = out_valid_q;
    assign bus.color_history = out_hist_q;
    assign bus.read_addr     = out_addr_q;
    assign bus.read_x        = out_x_q;
    assign bus.read_y        = out_y_q;
    assign bus.Cb            = out_cb_q;
    assign bus.Cr            = out_cr_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_short   = frame_short_q;
    assign bus.overrun       = overrun_q;
endmodule
